mem_bus_arbiter: RTL and testbench

- Two-requester arbiter that shares the single memory-side bus between the L1 instruction cache and the L1 data cache.
- Both caches use the same cyc/ack protocol:
  - reads: one address beat, then 8 response beats;
  - writes: one address beat, then 8 data beats.
- The arbiter locks the grant for a whole line transaction, counts beats to detect the end, then re-arbitrates round-robin.
- Sits between the cache pair and the memory/bus bridge.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared state, owner and tag-field definitions for the I/D memory bus arbiter.
package mem_bus_pkg;

  typedef logic [2:0] arb_state_t;
  localparam arb_state_t IDLE    = 3'd0;
  localparam arb_state_t ADDR    = 3'd1;
  localparam arb_state_t RDATA   = 3'd2;
  localparam arb_state_t WDATA   = 3'd3;
  localparam arb_state_t RELEASE = 3'd4;

  typedef logic owner_t;
  localparam owner_t OWN_I = 1'b0;
  localparam owner_t OWN_D = 1'b1;

  localparam int unsigned TAGW_DFLT = 13;
  localparam int unsigned READ_BIT  = TAGW_DFLT - 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to whoever did not own last.
module rr_pick2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == OWN_D) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the L1 I- and D-caches, locking the grant for a whole line.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDRW   = 64,
  parameter int unsigned TAGW    = READ_BIT + 1,
  parameter int unsigned BEATS   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_reqcyc,
  output logic             i_reqack,
  input  logic [ADDRW-1:0] i_req,
  input  logic [TAGW-1:0]  i_reqtag,
  output logic             i_respcyc,
  input  logic             i_respack,
  output logic [ADDRW-1:0] i_resp,
  output logic [TAGW-1:0]  i_resptag,
  input  logic             d_reqcyc,
  output logic             d_reqack,
  input  logic [ADDRW-1:0] d_req,
  input  logic [TAGW-1:0]  d_reqtag,
  output logic             d_respcyc,
  input  logic             d_respack,
  output logic [ADDRW-1:0] d_resp,
  output logic [TAGW-1:0]  d_resptag,
  output logic             bus_reqcyc,
  input  logic             bus_reqack,
  output logic [ADDRW-1:0] bus_req,
  output logic [TAGW-1:0]  bus_reqtag,
  input  logic             bus_respcyc,
  output logic             bus_respack,
  input  logic [ADDRW-1:0] bus_resp,
  input  logic [TAGW-1:0]  bus_resptag,
  output logic [1:0]       grant,
  output logic             timeout_err
);

  localparam int unsigned ReadBit = TAGW - 1;
  localparam int unsigned CntW    = $clog2(BEATS) + 1;
  localparam int unsigned WdW     = $clog2(TIMEOUT);

  arb_state_t      state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  owner_t          last_q, last_d;
  logic            is_read_q, is_read_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            terr_q, terr_d;
  logic [1:0]      pick;
  logic            req_hs, resp_hs, done;

  rr_pick2 u_pick (
    .req_i  ({d_reqcyc, i_reqcyc}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign grant       = grant_q;
  assign timeout_err = terr_q;

  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    i_reqack    = 1'b0;
    i_respcyc   = 1'b0;
    i_resp      = '0;
    i_resptag   = '0;
    d_reqack    = 1'b0;
    d_respcyc   = 1'b0;
    d_resp      = '0;
    d_resptag   = '0;
    unique case (grant_q)
      2'b01: begin
        bus_reqcyc  = i_reqcyc;
        bus_req     = i_req;
        bus_reqtag  = i_reqtag;
        bus_respack = i_respack;
        i_reqack    = bus_reqack;
        i_respcyc   = bus_respcyc;
        i_resp      = bus_resp;
        i_resptag   = bus_resptag;
      end
      2'b10: begin
        bus_reqcyc  = d_reqcyc;
        bus_req     = d_req;
        bus_reqtag  = d_reqtag;
        bus_respack = d_respack;
        d_reqack    = bus_reqack;
        d_respcyc   = bus_respcyc;
        d_resp      = bus_resp;
        d_resptag   = bus_resptag;
      end
      default: ;
    endcase
  end

  assign req_hs  = bus_reqcyc & bus_reqack;
  assign resp_hs = bus_respcyc & bus_respack;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    is_read_d = is_read_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    terr_d    = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick != 2'b00) begin
          grant_d   = pick;
          is_read_d = pick[0] ? i_reqtag[ReadBit] : d_reqtag[ReadBit];
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (req_hs) begin
          state_d = is_read_q ? RDATA : WDATA;
          cnt_d   = '0;
        end
      end
      RDATA: begin
        if (resp_hs) begin
          if (cnt_q == CntW'(BEATS - 1)) done = 1'b1;
          else                           cnt_d = cnt_q + CntW'(1);
        end
      end
      WDATA: begin
        if (req_hs) begin
          if (cnt_q == CntW'(BEATS - 1)) done = 1'b1;
          else                           cnt_d = cnt_q + CntW'(1);
        end
      end
      RELEASE: begin
        wd_d    = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Watchdog only runs while a transaction holds the bus; any handshake proves progress.
    if (state_q == ADDR || state_q == RDATA || state_q == WDATA) begin
      if (req_hs || resp_hs) begin
        wd_d = '0;
      end else if (wd_q == WdW'(TIMEOUT - 1)) begin
        terr_d = 1'b1;
        done   = 1'b1;
      end else begin
        wd_d = wd_q + WdW'(1);
      end
      if (done) begin
        state_d = RELEASE;
        grant_d = 2'b00;
        last_d  = grant_q[1] ? OWN_D : OWN_I;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= OWN_D;
      is_read_q <= 1'b0;
      cnt_q     <= '0;
      wd_q      <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      is_read_q <= is_read_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      terr_q    <= terr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDRW   = 64;
  localparam int unsigned TAGW    = 13;
  localparam int unsigned BEATS   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_reqcyc, i_reqack, i_respcyc, i_respack;
  logic [ADDRW-1:0] i_req, i_resp;
  logic [TAGW-1:0]  i_reqtag, i_resptag;
  logic             d_reqcyc, d_reqack, d_respcyc, d_respack;
  logic [ADDRW-1:0] d_req, d_resp;
  logic [TAGW-1:0]  d_reqtag, d_resptag;
  logic             bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [ADDRW-1:0] bus_req, bus_resp;
  logic [TAGW-1:0]  bus_reqtag, bus_resptag;
  logic [1:0]       grant;
  logic             timeout_err;

  int checks   = 0;
  int failures = 0;
  bit model_last;  // 0 = I, 1 = D: owner of the most recently finished transaction

  mem_bus_arbiter #(
    .ADDRW   (ADDRW),
    .TAGW    (TAGW),
    .BEATS   (BEATS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_reqcyc    (i_reqcyc),
    .i_reqack    (i_reqack),
    .i_req       (i_req),
    .i_reqtag    (i_reqtag),
    .i_respcyc   (i_respcyc),
    .i_respack   (i_respack),
    .i_resp      (i_resp),
    .i_resptag   (i_resptag),
    .d_reqcyc    (d_reqcyc),
    .d_reqack    (d_reqack),
    .d_req       (d_req),
    .d_reqtag    (d_reqtag),
    .d_respcyc   (d_respcyc),
    .d_respack   (d_respack),
    .d_resp      (d_resp),
    .d_resptag   (d_resptag),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input bit who);
    return who ? 2'b10 : 2'b01;
  endfunction

  // Lone requester wins; on a tie the one that did not go last wins.
  function automatic bit model_pick(input bit want_i, input bit want_d, input bit last);
    if (want_i && !want_d) return 1'b0;
    if (want_d && !want_i) return 1'b1;
    return !last;
  endfunction

  function automatic logic own_reqack(input bit who);
    return who ? d_reqack : i_reqack;
  endfunction

  function automatic logic own_respcyc(input bit who);
    return who ? d_respcyc : i_respcyc;
  endfunction

  function automatic logic [63:0] own_resp(input bit who);
    return who ? d_resp : i_resp;
  endfunction

  function automatic logic [12:0] own_resptag(input bit who);
    return who ? d_resptag : i_resptag;
  endfunction

  task automatic drive_req(input bit who, input logic cyc, input logic [63:0] data,
                           input logic [12:0] tag);
    if (who) begin
      d_reqcyc = cyc; d_req = data; d_reqtag = tag;
    end else begin
      i_reqcyc = cyc; i_req = data; i_reqtag = tag;
    end
  endtask

  task automatic drive_respack(input bit who, input logic v);
    if (who) d_respack = v;
    else     i_respack = v;
  endtask

  task automatic clear_inputs();
    drive_req(1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0);
    i_respack   = 1'b0;
    d_respack   = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'(0));
    check({tag, "_bus_reqcyc"}, 64'(bus_reqcyc), 64'(0));
    check({tag, "_bus_respack"}, 64'(bus_respack), 64'(0));
    check({tag, "_i_respcyc"}, 64'(i_respcyc), 64'(0));
    check({tag, "_i_resp"}, i_resp, 64'(0));
    check({tag, "_d_reqack"}, 64'(d_reqack), 64'(0));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
  endtask

  // Plays requester and memory for one line transaction starting in an IDLE cycle.
  // base != 0 gives data base+0..base+7, otherwise random. rst_beat >= 0 aborts by reset.
  task automatic serve(input bit who, input bit rd, input logic [63:0] addr,
                       input logic [63:0] base, input int rst_beat, input bit blip);
    logic [12:0] tag;
    logic [12:0] rtag;
    logic [63:0] val;
    tag = {rd, 12'($urandom)};
    drive_req(who, 1'b1, addr, tag);
    #1;
    check("idle_grant", 64'(grant), 64'(0));
    tick();
    bus_reqack = 1'b1;
    #1;
    check("addr_grant", 64'(grant), 64'(onehot(who)));
    check("addr_bus_reqcyc", 64'(bus_reqcyc), 64'(1));
    check("addr_bus_req", bus_req, addr);
    check("addr_bus_reqtag", 64'(bus_reqtag), 64'(tag));
    check("addr_own_reqack", 64'(own_reqack(who)), 64'(1));
    check("addr_other_reqack", 64'(own_reqack(!who)), 64'(0));
    tick();
    bus_reqack = 1'b0;
    if (rd) begin
      drive_req(who, 1'b0, '0, tag);
      for (int b = 0; b < int'(BEATS); b++) begin
        if (blip && b == 2) drive_req(1'b1, 1'b1, 64'h3000, 13'h1000);
        if (blip && b == 4) drive_req(1'b1, 1'b0, '0, '0);
        val  = (base != '0) ? base + 64'(b) : {$urandom, $urandom};
        rtag = 13'($urandom);
        bus_respcyc = 1'b1;
        bus_resp    = val;
        bus_resptag = rtag;
        drive_respack(who, 1'b1);
        #1;
        if (b == rst_beat) begin
          reset_n = 1'b0;
          #1;
          check_all_zero("async_rst");
          clear_inputs();
          tick();
          tick();
          reset_n    = 1'b1;
          model_last = 1'b1;
          return;
        end
        check("rd_grant", 64'(grant), 64'(onehot(who)));
        check("rd_own_respcyc", 64'(own_respcyc(who)), 64'(1));
        check("rd_own_resp", own_resp(who), val);
        check("rd_own_resptag", 64'(own_resptag(who)), 64'(rtag));
        check("rd_other_respcyc", 64'(own_respcyc(!who)), 64'(0));
        check("rd_bus_respack", 64'(bus_respack), 64'(1));
        tick();
      end
      bus_respcyc = 1'b0;
      drive_respack(who, 1'b0);
    end else begin
      for (int b = 0; b < int'(BEATS); b++) begin
        val = (base != '0) ? base + 64'(b) : {$urandom, $urandom};
        drive_req(who, 1'b1, val, tag);
        bus_reqack = 1'b1;
        #1;
        check("wr_grant", 64'(grant), 64'(onehot(who)));
        check("wr_bus_req", bus_req, val);
        check("wr_own_reqack", 64'(own_reqack(who)), 64'(1));
        check("wr_other_reqack", 64'(own_reqack(!who)), 64'(0));
        tick();
      end
      drive_req(who, 1'b0, '0, tag);
      bus_reqack = 1'b0;
    end
    #1;
    check("release_grant", 64'(grant), 64'(0));
    check("release_bus_reqcyc", 64'(bus_reqcyc), 64'(0));
    check("release_timeout_err", 64'(timeout_err), 64'(0));
    tick();
    model_last = who;
  endtask

  initial begin
    bit          win, rd_i, rd_d, want_i, want_d;
    logic [63:0] a_i, a_d;
    int          mode;

    reset_n    = 1'b0;
    model_last = 1'b1;
    clear_inputs();
    #3;
    check_all_zero("reset");
    tick();
    bus_respcyc = 1'b1;
    bus_reqack  = 1'b1;
    #1;
    check("reset_no_grant_d_respcyc", 64'(d_respcyc), 64'(0));
    check("reset_no_grant_i_reqack", 64'(i_reqack), 64'(0));
    clear_inputs();
    reset_n = 1'b1;
    tick();

    // I-cache read alone, then D-cache write.
    serve(model_pick(1'b1, 1'b0, model_last), 1'b1, 64'h1000, 64'hA0, -1, 1'b0);
    serve(model_pick(1'b0, 1'b1, model_last), 1'b0, 64'h2040, 64'hD0, -1, 1'b0);

    // Two simultaneous pairs.
    for (int p = 0; p < 2; p++) begin
      rd_i = 1'($urandom);
      rd_d = 1'($urandom);
      a_i  = {$urandom, $urandom};
      a_d  = {$urandom, $urandom};
      win  = model_pick(1'b1, 1'b1, model_last);
      drive_req(!win, 1'b1, win ? a_i : a_d, {win ? rd_i : rd_d, 12'h0});
      serve(win, win ? rd_d : rd_i, win ? a_d : a_i, '0, -1, 1'b0);
      serve(!win, win ? rd_i : rd_d, win ? a_i : a_d, '0, -1, 1'b0);
    end

    // Memory never accepts the address beat while the other cache waits.
    win = model_pick(1'b1, 1'b1, model_last);
    drive_req(1'b0, 1'b1, 64'h5000, 13'h1000);
    drive_req(1'b1, 1'b1, 64'h4000, 13'h1000);
    #1;
    check("to_idle_grant", 64'(grant), 64'(0));
    tick();
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      check("to_stall_grant", 64'(grant), 64'(onehot(win)));
      check("to_stall_err", 64'(timeout_err), 64'(0));
      tick();
    end
    check("to_pulse_err", 64'(timeout_err), 64'(1));
    check("to_pulse_grant", 64'(grant), 64'(0));
    drive_req(win, 1'b0, '0, '0);
    tick();
    check("to_after_err", 64'(timeout_err), 64'(0));
    check("to_after_grant", 64'(grant), 64'(0));
    model_last = win;
    serve(!win, 1'b1, 64'h4000, '0, -1, 1'b0);

    // Reset after three read beats, then a fresh full read.
    serve(1'b0, 1'b1, 64'h6000, '0, 3, 1'b0);
    serve(model_pick(1'b1, 1'b0, model_last), 1'b1, 64'h7000, 64'hB0, -1, 1'b0);

    // D raises and withdraws reqcyc while I owns the bus.
    serve(model_pick(1'b1, 1'b0, model_last), 1'b1, 64'h8000, '0, -1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("blip_no_grant", 64'(grant), 64'(0));
      tick();
    end

    // Randomized mix of single and simultaneous requests.
    for (int n = 0; n < 6; n++) begin
      mode   = int'($urandom_range(0, 2));
      want_i = (mode != 1);
      want_d = (mode != 0);
      rd_i   = 1'($urandom);
      rd_d   = 1'($urandom);
      a_i    = {$urandom, $urandom};
      a_d    = {$urandom, $urandom};
      win    = model_pick(want_i, want_d, model_last);
      if (want_i && want_d)
        drive_req(!win, 1'b1, win ? a_i : a_d, {win ? rd_i : rd_d, 12'h0});
      serve(win, win ? rd_d : rd_i, win ? a_d : a_i, '0, -1, 1'b0);
      if (want_i && want_d)
        serve(!win, win ? rd_i : rd_d, win ? a_i : a_d, '0, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
